// File: rtl/vending_pkg.sv
// Shared state encoding and arithmetic helpers for the multi-product vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    // Widest flat price table the slice helper accepts (16 products of up to 32 bits).
    localparam int PRICE_BUS_W = 512;
    localparam int PRICE_POS_W = 9;

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max_val
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

    function automatic logic [31:0] price_of(
        input logic [PRICE_BUS_W-1:0] flat,
        input logic [31:0]            idx,
        input logic [31:0]            width
    );
        logic [31:0]            val;
        logic [PRICE_POS_W-1:0] pos;
        val = 32'd0;
        for (int b = 0; b < 32; b++) begin
            pos    = PRICE_POS_W'(idx * width + 32'(b));
            val[b] = (32'(b) < width) ? flat[pos] : 1'b0;
        end
        return val;
    endfunction

endpackage

// File: rtl/vending_controller_multi_if.sv
// Front-end / actuator bus of the vending controller: coin, keypad, restock, dispense and change.
interface vending_controller_multi_if #(
    parameter int NUM_PROD = 4,
    parameter int SEL_W    = 2,
    parameter int CASH_W   = 8,
    parameter int CNT_W    = 4
);
    logic                       coin_valid;
    logic [CASH_W-1:0]          coin_value;
    logic                       sel_valid;
    logic [SEL_W-1:0]           sel;
    logic                       cancel;
    logic                       change_ack;
    logic                       restock_valid;
    logic [SEL_W-1:0]           restock_id;
    logic [CNT_W-1:0]           restock_qty;
    logic [NUM_PROD*CASH_W-1:0] prices;
    logic [CASH_W-1:0]          credit;
    logic                       dispense;
    logic [SEL_W-1:0]           dispense_id;
    logic                       change_valid;
    logic [CASH_W-1:0]          change_amt;
    logic                       coin_reject;
    logic                       err_sel;
    logic                       err_sold_out;
    logic                       err_funds;
    logic [NUM_PROD*CNT_W-1:0]  counts;
    logic                       busy;

    modport master (
        output coin_valid, coin_value, sel_valid, sel, cancel, change_ack,
               restock_valid, restock_id, restock_qty, prices,
        input  credit, dispense, dispense_id, change_valid, change_amt,
               coin_reject, err_sel, err_sold_out, err_funds, counts, busy
    );

    modport slave (
        input  coin_valid, coin_value, sel_valid, sel, cancel, change_ack,
               restock_valid, restock_id, restock_qty, prices,
        output credit, dispense, dispense_id, change_valid, change_amt,
               coin_reject, err_sel, err_sold_out, err_funds, counts, busy
    );
endinterface

// File: rtl/vending_inventory.sv
// Per-product stock counters with vend decrement and saturating restock merged in one update.
module vending_inventory
    import vending_pkg::*;
#(
    parameter int NUM_PROD   = 4,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 4,
    parameter int INIT_COUNT = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dec_valid,
    input  logic [SEL_W-1:0]          dec_id,
    input  logic                      restock_valid,
    input  logic [SEL_W-1:0]          restock_id,
    input  logic [CNT_W-1:0]          restock_qty,
    output logic [NUM_PROD*CNT_W-1:0] counts
);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] count_r      [NUM_PROD];
    logic [CNT_W-1:0] base_s       [NUM_PROD];
    logic [CNT_W-1:0] add_s        [NUM_PROD];
    logic [CNT_W-1:0] count_next_s [NUM_PROD];

    // Decrement first, then add restock, so a same-cycle hit saturates on count - 1 + qty.
    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) begin
            base_s[i] = count_r[i] -
                (((dec_valid && (dec_id == SEL_W'(i))) && (count_r[i] != '0)) ? CNT_W'(1) : CNT_W'(0));
            add_s[i]  = (restock_valid && (restock_id == SEL_W'(i))) ? restock_qty : CNT_W'(0);
            count_next_s[i] = CNT_W'(sat_add(32'(base_s[i]), 32'(add_s[i]), CNT_MAX));
        end
    end

    // Counter array state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                count_r[i] <= CNT_W'(INIT_COUNT);
            end
        end else begin
            for (int i = 0; i < NUM_PROD; i++) begin
                count_r[i] <= count_next_s[i];
            end
        end
    end

    // Flatten the registered counters onto the output bus.
    always_comb begin
        counts = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            counts[i*CNT_W +: CNT_W] = count_r[i];
        end
    end

endmodule

// File: rtl/vending_controller_multi.sv
// Multi-coin, multi-product vending controller: credit FSM, vend sequencing and change handshake.
module vending_controller_multi
    import vending_pkg::*;
#(
    parameter int NUM_PROD   = 4,
    parameter int SEL_W      = 2,
    parameter int CASH_W     = 8,
    parameter int CNT_W      = 4,
    parameter int INIT_COUNT = 5
) (
    input logic                       clk,
    input logic                       rst,
    vending_controller_multi_if.slave bus
);
    state_t                    state_r;
    logic [CASH_W-1:0]         credit_r;
    logic [CASH_W-1:0]         change_amt_r;
    logic [SEL_W-1:0]          dispense_id_r;
    logic                      dispense_r;
    logic                      change_valid_r;
    logic                      coin_reject_r;
    logic                      err_sel_r;
    logic                      err_sold_out_r;
    logic                      err_funds_r;
    logic                      busy_r;

    logic [NUM_PROD*CNT_W-1:0] counts_s;
    logic [CASH_W:0]           coin_sum_s;
    logic [CASH_W-1:0]         sel_price_s;
    logic [CNT_W-1:0]          sel_count_s;
    logic                      sel_in_range_s;
    logic                      dec_valid_s;

    // Selection lookups and the overflow-aware coin sum, all taken from the current edge's inputs.
    always_comb begin
        coin_sum_s     = {1'b0, credit_r} + {1'b0, bus.coin_value};
        sel_in_range_s = 1'b0;
        sel_count_s    = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            sel_in_range_s = sel_in_range_s | (bus.sel == SEL_W'(i));
            sel_count_s    = (bus.sel == SEL_W'(i)) ? counts_s[i*CNT_W +: CNT_W] : sel_count_s;
        end
        sel_price_s = CASH_W'(price_of(PRICE_BUS_W'(bus.prices), 32'(bus.sel), 32'(CASH_W)));
    end

    assign dec_valid_s = (state_r == ST_VEND);

    vending_inventory #(
        .NUM_PROD   (NUM_PROD),
        .SEL_W      (SEL_W),
        .CNT_W      (CNT_W),
        .INIT_COUNT (INIT_COUNT)
    ) u_inventory (
        .clk           (clk),
        .rst           (rst),
        .dec_valid     (dec_valid_s),
        .dec_id        (dispense_id_r),
        .restock_valid (bus.restock_valid),
        .restock_id    (bus.restock_id),
        .restock_qty   (bus.restock_qty),
        .counts        (counts_s)
    );

    // Controller FSM; pulses default low each cycle and every output is a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            credit_r       <= '0;
            change_amt_r   <= '0;
            dispense_id_r  <= '0;
            dispense_r     <= 1'b0;
            change_valid_r <= 1'b0;
            coin_reject_r  <= 1'b0;
            err_sel_r      <= 1'b0;
            err_sold_out_r <= 1'b0;
            err_funds_r    <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            dispense_r     <= 1'b0;
            coin_reject_r  <= 1'b0;
            err_sel_r      <= 1'b0;
            err_sold_out_r <= 1'b0;
            err_funds_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.coin_valid) begin
                        if (bus.coin_value == '0) begin
                            coin_reject_r <= 1'b1;
                        end else begin
                            credit_r <= bus.coin_value;
                            state_r  <= ST_CREDIT;
                        end
                    end
                end
                ST_CREDIT: begin
                    if (bus.cancel) begin
                        coin_reject_r  <= bus.coin_valid;
                        change_valid_r <= 1'b1;
                        change_amt_r   <= credit_r;
                        busy_r         <= 1'b1;
                        state_r        <= ST_CHANGE;
                    end else if (bus.sel_valid) begin
                        coin_reject_r <= bus.coin_valid;
                        if (!sel_in_range_s) begin
                            err_sel_r <= 1'b1;
                        end else if (sel_count_s == '0) begin
                            err_sold_out_r <= 1'b1;
                        end else if (credit_r < sel_price_s) begin
                            err_funds_r <= 1'b1;
                        end else begin
                            dispense_r    <= 1'b1;
                            dispense_id_r <= bus.sel;
                            credit_r      <= credit_r - sel_price_s;
                            busy_r        <= 1'b1;
                            state_r       <= ST_VEND;
                        end
                    end else if (bus.coin_valid) begin
                        if (coin_sum_s[CASH_W]) begin
                            coin_reject_r <= 1'b1;
                        end else begin
                            credit_r <= coin_sum_s[CASH_W-1:0];
                        end
                    end
                end
                ST_VEND: begin
                    coin_reject_r <= bus.coin_valid;
                    if (credit_r != '0) begin
                        change_valid_r <= 1'b1;
                        change_amt_r   <= credit_r;
                        state_r        <= ST_CHANGE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_CHANGE: begin
                    coin_reject_r <= bus.coin_valid;
                    if (bus.change_ack) begin
                        credit_r       <= '0;
                        change_valid_r <= 1'b0;
                        change_amt_r   <= '0;
                        busy_r         <= 1'b0;
                        state_r        <= ST_IDLE;
                    end
                end
                default: begin
                    credit_r       <= '0;
                    change_valid_r <= 1'b0;
                    change_amt_r   <= '0;
                    busy_r         <= 1'b0;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.credit       = credit_r;
    assign bus.dispense     = dispense_r;
    assign bus.dispense_id  = dispense_id_r;
    assign bus.change_valid = change_valid_r;
    assign bus.change_amt   = change_amt_r;
    assign bus.coin_reject  = coin_reject_r;
    assign bus.err_sel      = err_sel_r;
    assign bus.err_sold_out = err_sold_out_r;
    assign bus.err_funds    = err_funds_r;
    assign bus.counts       = counts_s;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_vending_controller_multi.sv
// Bench for vending_controller_multi: directed vector table, corner sequences, random run vs. a credit/stock model.
module tb_vending_controller_multi;
    localparam int NP   = 3;
    localparam int SW   = 2;
    localparam int CW   = 8;
    localparam int NW   = 4;
    localparam int INIT = 5;
    localparam int CASH_MAX = (1 << CW) - 1;
    localparam int CNT_MAX  = (1 << NW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vending_controller_multi_if #(.NUM_PROD(NP), .SEL_W(SW), .CASH_W(CW), .CNT_W(NW)) bus ();

    vending_controller_multi #(
        .NUM_PROD(NP), .SEL_W(SW), .CASH_W(CW), .CNT_W(NW), .INIT_COUNT(INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: money held, stock per product, a pending dispense and a pending refund.
    int m_credit;
    int m_cnt [NP];
    bit m_vend;
    int m_vend_id;
    bit m_refund;
    int m_refund_amt;
    bit e_rej, e_esel, e_eso, e_efund;

    typedef struct {
        logic          cv;
        logic [CW-1:0] cval;
        logic          sv;
        logic [SW-1:0] s;
        logic          can;
        logic          ack;
        int            e_credit;
        logic          e_disp;
        logic          e_cvalid;
        int            e_camt;
        logic          e_rej;
        logic [2:0]    e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic cv, int cval, logic sv, int s, logic can, logic ack,
                                int ecr, logic ed, logic ecv, int eca, logic erj, logic [2:0] eer);
        vec_t v;
        v.cv = cv; v.cval = CW'(cval); v.sv = sv; v.s = SW'(s); v.can = can; v.ack = ack;
        v.e_credit = ecr; v.e_disp = ed; v.e_cvalid = ecv; v.e_camt = eca; v.e_rej = erj; v.e_err = eer;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        for (int p = 0; p < NP; p++) m_cnt[p] = INIT;
        m_vend = 1'b0; m_vend_id = 0; m_refund = 1'b0; m_refund_amt = 0;
        e_rej = 1'b0; e_esel = 1'b0; e_eso = 1'b0; e_efund = 1'b0;
    endtask

    task automatic model_step();
        int old_cnt [NP];
        bit was_vend;
        int vid, price, sidx, n;
        for (int p = 0; p < NP; p++) old_cnt[p] = m_cnt[p];
        was_vend = m_vend;
        vid = m_vend_id;
        e_rej = 1'b0; e_esel = 1'b0; e_eso = 1'b0; e_efund = 1'b0;
        if (was_vend) begin
            m_vend = 1'b0;
            e_rej = bus.coin_valid;
            if (m_credit != 0) begin
                m_refund = 1'b1;
                m_refund_amt = m_credit;
            end
        end else if (m_refund) begin
            e_rej = bus.coin_valid;
            if (bus.change_ack) begin
                m_refund = 1'b0; m_refund_amt = 0; m_credit = 0;
            end
        end else if (m_credit == 0) begin
            if (bus.coin_valid) begin
                if (bus.coin_value == 0) e_rej = 1'b1;
                else m_credit = int'(bus.coin_value);
            end
        end else begin
            if (bus.cancel) begin
                e_rej = bus.coin_valid;
                m_refund = 1'b1;
                m_refund_amt = m_credit;
            end else if (bus.sel_valid) begin
                e_rej = bus.coin_valid;
                sidx = int'(bus.sel);
                if (sidx >= NP) e_esel = 1'b1;
                else begin
                    price = int'(bus.prices[sidx*CW +: CW]);
                    if (old_cnt[sidx] == 0) e_eso = 1'b1;
                    else if (m_credit < price) e_efund = 1'b1;
                    else begin
                        m_credit -= price;
                        m_vend = 1'b1;
                        m_vend_id = sidx;
                    end
                end
            end else if (bus.coin_valid) begin
                if (m_credit + int'(bus.coin_value) > CASH_MAX) e_rej = 1'b1;
                else m_credit += int'(bus.coin_value);
            end
        end
        for (int p = 0; p < NP; p++) begin
            n = old_cnt[p];
            if (was_vend && p == vid) n--;
            if (bus.restock_valid && int'(bus.restock_id) == p) n += int'(bus.restock_qty);
            m_cnt[p] = (n > CNT_MAX) ? CNT_MAX : n;
        end
    endtask

    task automatic check_outputs();
        chk("credit", 32'(bus.credit), m_credit);
        chk("dispense", 32'(bus.dispense), 32'(m_vend));
        if (m_vend) chk("dispense_id", 32'(bus.dispense_id), m_vend_id);
        chk("change_valid", 32'(bus.change_valid), 32'(m_refund));
        chk("change_amt", 32'(bus.change_amt), m_refund_amt);
        chk("coin_reject", 32'(bus.coin_reject), 32'(e_rej));
        chk("err_sel", 32'(bus.err_sel), 32'(e_esel));
        chk("err_sold_out", 32'(bus.err_sold_out), 32'(e_eso));
        chk("err_funds", 32'(bus.err_funds), 32'(e_efund));
        chk("busy", 32'(bus.busy), 32'(m_vend || m_refund));
        for (int p = 0; p < NP; p++) chk($sformatf("count%0d", p), 32'(bus.counts[p*NW +: NW]), m_cnt[p]);
    endtask

    task automatic clear_inputs();
        bus.coin_valid = 1'b0; bus.coin_value = '0; bus.sel_valid = 1'b0; bus.sel = '0;
        bus.cancel = 1'b0; bus.change_ack = 1'b0;
        bus.restock_valid = 1'b0; bus.restock_id = '0; bus.restock_qty = '0;
    endtask

    task automatic set_in(input logic cv, input logic [CW-1:0] cval, input logic sv, input logic [SW-1:0] s,
                          input logic can, input logic ack, input logic rv, input logic [SW-1:0] rid,
                          input logic [NW-1:0] rq);
        bus.coin_valid = cv; bus.coin_value = cval; bus.sel_valid = sv; bus.sel = s;
        bus.cancel = can; bus.change_ack = ack;
        bus.restock_valid = rv; bus.restock_id = rid; bus.restock_qty = rq;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        clear_inputs();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_dispense_id", 32'(bus.dispense_id), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    int coin_vals [8] = '{0, 1, 5, 10, 25, 50, 100, 200};

    initial begin
        rst = 1'b0;
        clear_inputs();
        bus.prices = {8'd30, 8'd20, 8'd10};
        model_reset();

        vecs.push_back(mk(1, 10, 0, 0, 0, 0,  10, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 10, 0, 0, 0, 0,  20, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1,  5, 0, 0, 0, 0,  25, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(0,  0, 1, 1, 0, 0,   5, 1, 0, 0, 0, 3'b000));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0,   5, 0, 1, 5, 0, 3'b000));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0,   5, 0, 1, 5, 0, 3'b000));
        vecs.push_back(mk(0,  0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 15, 0, 0, 0, 0,  15, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(0,  0, 1, 2, 0, 0,  15, 0, 0, 0, 0, 3'b001));
        vecs.push_back(mk(1,  5, 1, 1, 0, 0,  15, 0, 0, 0, 1, 3'b001));
        vecs.push_back(mk(1, 10, 0, 0, 1, 0,  15, 0, 1, 15, 1, 3'b000));
        vecs.push_back(mk(1, 10, 0, 0, 0, 0,  15, 0, 1, 15, 1, 3'b000));
        vecs.push_back(mk(0,  0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(0,  0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(0,  0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1,  0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 3'b000));
        vecs.push_back(mk(0,  0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1,200, 0, 0, 0, 0, 200, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 50, 0, 0, 0, 0, 250, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 10, 0, 0, 0, 0, 250, 0, 0, 0, 1, 3'b000));
        vecs.push_back(mk(1,  5, 0, 0, 0, 0, 255, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 255, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(0,  0, 0, 0, 1, 0, 255, 0, 1, 255, 0, 3'b000));
        vecs.push_back(mk(0,  0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 10, 0, 0, 0, 0,  10, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(0,  0, 1, 3, 0, 0,  10, 0, 0, 0, 0, 3'b100));
        vecs.push_back(mk(0,  0, 0, 0, 1, 0,  10, 0, 1, 10, 0, 3'b000));
        vecs.push_back(mk(0,  0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 3'b000));

        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_dispense_id", 32'(bus.dispense_id), 0);
        rst = 1'b1;

        // Directed vector table: coin accumulation, vend with change, funds/select errors, overflow.
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].cv, vecs[i].cval, vecs[i].sv, vecs[i].s, vecs[i].can, vecs[i].ack, 1'b0, 2'd0, 4'd0);
            step();
            chk($sformatf("vec%0d_credit", i), 32'(bus.credit), vecs[i].e_credit);
            chk($sformatf("vec%0d_dispense", i), 32'(bus.dispense), 32'(vecs[i].e_disp));
            chk($sformatf("vec%0d_change_valid", i), 32'(bus.change_valid), 32'(vecs[i].e_cvalid));
            chk($sformatf("vec%0d_change_amt", i), 32'(bus.change_amt), vecs[i].e_camt);
            chk($sformatf("vec%0d_coin_reject", i), 32'(bus.coin_reject), 32'(vecs[i].e_rej));
            chk($sformatf("vec%0d_errs", i), 32'({bus.err_sel, bus.err_sold_out, bus.err_funds}), 32'(vecs[i].e_err));
        end
        chk("count1_after_vend", 32'(bus.counts[NW +: NW]), 4);

        // Drain product 0 with exact-price vends, then sold-out and restock.
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 8'd10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
            set_in(1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
            chk("drain_dispense", 32'(bus.dispense), 1);
            step();
            chk("drain_no_change", 32'(bus.change_valid), 0);
            chk("drain_idle", 32'(bus.busy), 0);
        end
        chk("drain_count0", 32'(bus.counts[0 +: NW]), 0);
        set_in(1'b1, 8'd10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        set_in(1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        chk("sold_out", 32'(bus.err_sold_out), 1);
        set_in(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd3); step();
        chk("restock_count0", 32'(bus.counts[0 +: NW]), 3);
        set_in(1'b0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0); step();
        set_in(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0); step();

        // Restock coinciding with the vend decrement, saturated and unsaturated.
        set_in(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd10); step();
        chk("restock_to_15", 32'(bus.counts[2*NW +: NW]), 15);
        set_in(1'b1, 8'd30, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        set_in(1'b1, 8'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        set_in(1'b0, 8'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        chk("vend2_dispense_id", 32'(bus.dispense_id), 2);
        set_in(1'b1, 8'd10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd4); step();
        chk("vend_restock_sat", 32'(bus.counts[2*NW +: NW]), 15);
        chk("vend_coin_reject", 32'(bus.coin_reject), 1);
        chk("vend_change_amt", 32'(bus.change_amt), 5);
        set_in(1'b1, 8'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        chk("change_coin_reject", 32'(bus.coin_reject), 1);
        set_in(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0); step();
        set_in(1'b1, 8'd20, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        set_in(1'b0, 8'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        set_in(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd2); step();
        chk("vend_restock_merge", 32'(bus.counts[NW +: NW]), 5);

        // Reset in the middle of a change handshake, then an out-of-range select.
        set_in(1'b1, 8'd25, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        set_in(1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        step();
        chk("pre_reset_change_valid", 32'(bus.change_valid), 1);
        apply_reset();
        chk("post_reset_count0", 32'(bus.counts[0 +: NW]), INIT);
        set_in(1'b1, 8'd10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        set_in(1'b0, 8'd0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0); step();
        chk("err_sel_3", 32'(bus.err_sel), 1);
        set_in(1'b0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0); step();
        set_in(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0); step();

        // Random traffic against the model, with occasional price changes.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                int pi;
                pi = $urandom_range(0, NP - 1);
                bus.prices[pi*CW +: CW] = CW'($urandom_range(0, 60));
            end
            set_in($urandom_range(0, 9) < 4, CW'(coin_vals[$urandom_range(0, 7)]),
                   $urandom_range(0, 4) == 0, SW'($urandom_range(0, 3)),
                   $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 19) == 0, SW'($urandom_range(0, 3)), NW'($urandom_range(0, 15)));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vending_controller_multi.md
Name: vending_controller_multi

Overview:
Parametrised, clocked successor to the single-shot vending datapath. It accumulates credit from multiple coin insertions and supports N products with run-time programmable prices. It sequences vend and change-return through a state machine with a change handshake, and manages per-product inventory with restock. It sits between the coin/keypad front end and the dispenser/change-return actuators.

Parameters:
NUM_PROD, 4, number of products (2..16)
SEL_W, 2, product-select width; must satisfy 2**SEL_W >= NUM_PROD
CASH_W, 8, width of coin, price, credit and change values
CNT_W, 4, width of each inventory counter
INIT_COUNT, 5, inventory value loaded into every product at reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserts immediately; deassertion synchronous to clk upstream)
coin_valid  in  1  one-cycle strobe: coin inserted
coin_value  in  CASH_W  value of inserted coin
sel_valid  in  1  one-cycle strobe: product selected
sel  in  SEL_W  product index
cancel  in  1  one-cycle strobe: refund credit
change_ack  in  1  change actuator accepted change_amt
restock_valid  in  1  one-cycle strobe: add stock
restock_id  in  SEL_W  product to restock
restock_qty  in  CNT_W  quantity to add
prices  in  NUM_PROD*CASH_W  flat price table; product i occupies bits [i*CASH_W +: CASH_W]
credit  out  CASH_W  current accumulated credit
dispense  out  1  one-cycle pulse: release product
dispense_id  out  SEL_W  product released; valid while dispense is high
change_valid  out  1  change request; held until change_ack
change_amt  out  CASH_W  change value; stable while change_valid is high
coin_reject  out  1  one-cycle pulse: coin not accepted
err_sel  out  1  one-cycle pulse: sel >= NUM_PROD
err_sold_out  out  1  one-cycle pulse: selected product count is 0
err_funds  out  1  one-cycle pulse: credit < price
counts  out  NUM_PROD*CNT_W  flat inventory counts
busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset values: state IDLE; credit 0; every count INIT_COUNT; all pulses, change_valid, change_amt, dispense_id and busy at 0. A reset mid-vend or mid-change discards credit and aborts the handshake.
- IDLE (credit == 0):
  - coin_valid -> credit = coin_value, go to CREDIT.
  - coin_value == 0 -> coin_reject, stay in IDLE.
  - sel_valid and cancel are ignored.
- CREDIT. Priority within a cycle: cancel > sel_valid > coin_valid. A lower-priority coin in the same cycle gets coin_reject.
  - cancel -> CHANGE with change_amt = credit.
  - sel_valid, evaluated in order:
    - sel >= NUM_PROD -> err_sel.
    - count[sel] == 0 -> err_sold_out.
    - credit < price[sel] -> err_funds.
    - Otherwise latch dispense_id = sel, credit <= credit - price[sel], go to VEND.
    - On any error, stay in CREDIT with credit unchanged.
  - coin_valid: if credit + coin_value > 2**CASH_W - 1 -> coin_reject, credit unchanged; else credit += coin_value. Compute the sum at CASH_W+1 bits.
- VEND (exactly one cycle):
  - dispense = 1; count[dispense_id] decrements.
  - Next state CHANGE if credit != 0, else IDLE.
- CHANGE:
  - change_valid = 1, change_amt = credit.
  - change_ack -> credit 0, change_valid drops next cycle, go to IDLE.
  - change_ack outside CHANGE is ignored.
- Coins arriving in VEND or CHANGE get coin_reject. sel_valid and cancel are ignored in VEND and CHANGE.
- Latency: sel accepted at edge t -> dispense high during cycle t+1 -> change_valid high from cycle t+2.
- Restock (any state):
  - count[restock_id] += restock_qty, saturating at 2**CNT_W - 1.
  - restock_id >= NUM_PROD is ignored.
  - Same cycle and same product as the VEND decrement: new count = sat(count - 1 + qty).
- Prices are sampled only at the selection edge; later changes do not affect a vend in flight.
- All outputs are registered.

Decomposition:
- Shared package vending_pkg holds:
  - state enum ST_IDLE, ST_CREDIT, ST_VEND, ST_CHANGE (2-bit encoding);
  - a function for saturating add;
  - a function extracting the price slice.
- One sub-module, vending_inventory: holds the NUM_PROD counter array, with decrement and restock ports plus merged saturation logic. The FSM and credit datapath stay in the top level.

Test Plan:
1. Reset with prices {10,20,30,40}; coins 10,10,5; sel=1 -> dispense at t+1 with dispense_id=1; count[1]=4; change_valid with change_amt=5; change_ack -> IDLE, credit 0.
2. Credit 15, sel=2 -> err_funds, credit stays 15; cancel -> change_amt=15.
3. Drain product 0 through 5 exact-price vends (no CHANGE entered); 6th sel=0 -> err_sold_out; restock qty=3 -> count[0]=3.
4. CASH_W=8, credit 250, coin 10 -> coin_reject, credit 250; coin 5 -> credit 255.
5. In the VEND cycle of product 3 (count 15), restock product 3 with qty 4 -> count 15 (saturated); a coin during CHANGE -> coin_reject.
6. Assert rst while change_valid is high -> all outputs at reset values; counts = INIT_COUNT; sel=3 with NUM_PROD=3 -> err_sel.
